// File: rtl/bp_pkg.sv
// Shared constants for the bimodal branch predictor / BTB.
package bp_pkg;

  // 2-bit saturating counter encodings; the MSB is the taken prediction.
  localparam logic [1:0] CTR_SNT = 2'b00;
  localparam logic [1:0] CTR_WNT = 2'b01;
  localparam logic [1:0] CTR_WT  = 2'b10;
  localparam logic [1:0] CTR_ST  = 2'b11;

  // Freshly allocated entries start weakly taken.
  localparam logic [1:0] CTR_INIT_TAKEN = CTR_WT;

  // PCs are word aligned: the index starts above the two byte-offset bits,
  // and the tag starts directly above the index.
  localparam int IDX_LSB = 2;

endpackage

// File: rtl/bp_sat_ctr2.sv
// 2-bit saturating counter next-state function (pure combinational).
module bp_sat_ctr2
  import bp_pkg::*;
(
  input  logic [1:0] ctr_i,
  input  logic       taken_i,
  output logic [1:0] ctr_o
);

  // Step toward ST on taken, toward SNT on not-taken, clamping at the ends.
  always_comb begin
    ctr_o = ctr_i;
    if (taken_i) begin
      if (ctr_i != CTR_ST) ctr_o = ctr_i + 2'd1;
    end else begin
      if (ctr_i != CTR_SNT) ctr_o = ctr_i - 2'd1;
    end
  end

endmodule

// File: rtl/branch_predictor_btb.sv
// Bimodal branch predictor with a direct-mapped BTB. Lookup is combinational
// from the fetch PC; training happens on the clock edge from EX results.
module branch_predictor_btb
  import bp_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int IDX_W = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] if_pc,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target,
  input  logic            ex_upd,
  input  logic [XLEN-1:0] ex_pc,
  input  logic            ex_taken,
  input  logic [XLEN-1:0] ex_target,
  output logic            ex_mispredict
);

  localparam int ENTRIES = 2 ** IDX_W;
  localparam int TAG_W   = XLEN - IDX_W - IDX_LSB;
  localparam int TAG_LSB = IDX_W + IDX_LSB;

  logic             valid_q  [ENTRIES];
  logic             valid_d  [ENTRIES];
  logic [TAG_W-1:0] tag_q    [ENTRIES];
  logic [TAG_W-1:0] tag_d    [ENTRIES];
  logic [XLEN-1:0]  target_q [ENTRIES];
  logic [XLEN-1:0]  target_d [ENTRIES];
  logic [1:0]       ctr_q    [ENTRIES];
  logic [1:0]       ctr_d    [ENTRIES];
  logic             ex_mispredict_q;
  logic             ex_mispredict_d;

  logic [IDX_W-1:0] lk_idx;
  logic [TAG_W-1:0] lk_tag;
  logic             lk_hit;
  logic [IDX_W-1:0] up_idx;
  logic [TAG_W-1:0] up_tag;
  logic             up_hit;
  logic             up_pred;
  logic [1:0]       up_ctr_nxt;

  // Byte-offset bits of both PCs never participate in index or tag.
  logic unused_pc_lsbs;
  assign unused_pc_lsbs = ^{if_pc[IDX_LSB-1:0], ex_pc[IDX_LSB-1:0]};

  // Fetch-side lookup: reads only registered state, so no bypass from EX.
  always_comb begin
    lk_idx      = if_pc[TAG_LSB-1:IDX_LSB];
    lk_tag      = if_pc[XLEN-1:TAG_LSB];
    lk_hit      = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    pred_taken  = lk_hit && ctr_q[lk_idx][1];
    pred_target = pred_taken ? target_q[lk_idx] : '0;
  end

  // Decode the EX-side index/tag and what the table would have predicted.
  always_comb begin
    up_idx  = ex_pc[TAG_LSB-1:IDX_LSB];
    up_tag  = ex_pc[XLEN-1:TAG_LSB];
    up_hit  = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
    up_pred = up_hit && ctr_q[up_idx][1];
  end

  bp_sat_ctr2 u_sat_ctr (
    .ctr_i   (ctr_q[up_idx]),
    .taken_i (ex_taken),
    .ctr_o   (up_ctr_nxt)
  );

  // Training: adjust the counter on a hit, allocate on a taken miss, and
  // flag a misprediction on a wrong direction or a stale taken target.
  always_comb begin
    valid_d         = valid_q;
    tag_d           = tag_q;
    target_d        = target_q;
    ctr_d           = ctr_q;
    ex_mispredict_d = 1'b0;
    if (ex_upd) begin
      ex_mispredict_d = (up_pred != ex_taken) ||
                        (up_pred && ex_taken && (target_q[up_idx] != ex_target));
      if (up_hit) begin
        ctr_d[up_idx] = up_ctr_nxt;
        if (ex_taken) target_d[up_idx] = ex_target;
      end else if (ex_taken) begin
        valid_d[up_idx]  = 1'b1;
        tag_d[up_idx]    = up_tag;
        target_d[up_idx] = ex_target;
        ctr_d[up_idx]    = CTR_INIT_TAKEN;
      end
    end
  end

  // Table and mispredict flag registers; reset wipes the whole table at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= CTR_SNT;
      end
      ex_mispredict_q <= 1'b0;
    end else begin
      valid_q         <= valid_d;
      tag_q           <= tag_d;
      target_q        <= target_d;
      ctr_q           <= ctr_d;
      ex_mispredict_q <= ex_mispredict_d;
    end
  end

  assign ex_mispredict = ex_mispredict_q;

endmodule

// File: tb/tb_branch_predictor_btb.sv
// Directed self-checking bench for branch_predictor_btb.
module tb_branch_predictor_btb;

  logic        clk;
  logic        rst_n;
  logic [31:0] if_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        ex_upd;
  logic [31:0] ex_pc;
  logic        ex_taken;
  logic [31:0] ex_target;
  logic        ex_mispredict;

  int checks = 0;
  int errors = 0;

  branch_predictor_btb #(.XLEN(32), .IDX_W(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .if_pc         (if_pc),
    .pred_taken    (pred_taken),
    .pred_target   (pred_target),
    .ex_upd        (ex_upd),
    .ex_pc         (ex_pc),
    .ex_taken      (ex_taken),
    .ex_target     (ex_target),
    .ex_mispredict (ex_mispredict)
  );

  // 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive EX-side training inputs and the fetch PC together.
  task automatic applyStimulus(input logic upd, input logic [31:0] pc,
                               input logic taken, input logic [31:0] target,
                               input logic [31:0] fetch_pc);
    ex_upd    = upd;
    ex_pc     = pc;
    ex_taken  = taken;
    ex_target = target;
    if_pc     = fetch_pc;
    #1;
  endtask

  // One comparison point.
  task automatic checkOutput(input string name, input logic [31:0] obs,
                             input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  // Perform one training update, then return to idle with fetch_pc on IF.
  task automatic train(input logic [31:0] pc, input logic taken,
                       input logic [31:0] target, input logic [31:0] fetch_pc);
    applyStimulus(1'b1, pc, taken, target, fetch_pc);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, fetch_pc);
  endtask

  initial begin
    rst_n = 1'b0;
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 32'h0000_0100);

    // Reset state.
    checkOutput("rst_pred_taken", {31'b0, pred_taken}, 32'h0);
    checkOutput("rst_pred_target", pred_target, 32'h0);
    checkOutput("rst_mispredict", {31'b0, ex_mispredict}, 32'h0);
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    checkOutput("post_rst_pred_taken", {31'b0, pred_taken}, 32'h0);
    checkOutput("idle_mispredict", {31'b0, ex_mispredict}, 32'h0);

    // Allocate 0x100 -> 0x80 while fetching 0x100: no bypass this cycle.
    applyStimulus(1'b1, 32'h100, 1'b1, 32'h80, 32'h100);
    checkOutput("same_cycle_pred_taken", {31'b0, pred_taken}, 32'h0);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 32'h100);
    checkOutput("alloc_mispredict", {31'b0, ex_mispredict}, 32'h1);
    checkOutput("alloc_pred_taken", {31'b0, pred_taken}, 32'h1);
    checkOutput("alloc_pred_target", pred_target, 32'h80);
    tick();
    checkOutput("idle_after_upd_mispredict", {31'b0, ex_mispredict}, 32'h0);

    // 10 -> 11 -> 11 (saturate); correct predictions, no mispredict.
    train(32'h100, 1'b1, 32'h80, 32'h100);
    checkOutput("taken1_mispredict", {31'b0, ex_mispredict}, 32'h0);
    train(32'h100, 1'b1, 32'h80, 32'h100);
    checkOutput("taken2_mispredict", {31'b0, ex_mispredict}, 32'h0);

    // 11 -> 10: still predicts taken.
    train(32'h100, 1'b0, 32'h0, 32'h100);
    checkOutput("nt1_mispredict", {31'b0, ex_mispredict}, 32'h1);
    checkOutput("nt1_pred_taken", {31'b0, pred_taken}, 32'h1);
    checkOutput("nt1_pred_target", pred_target, 32'h80);

    // 10 -> 01: now predicts not-taken.
    train(32'h100, 1'b0, 32'h0, 32'h100);
    checkOutput("nt2_mispredict", {31'b0, ex_mispredict}, 32'h1);
    checkOutput("nt2_pred_taken", {31'b0, pred_taken}, 32'h0);
    checkOutput("nt2_pred_target", pred_target, 32'h0);

    // 01 -> 10 (mispredict), 10 -> 11 (correct).
    train(32'h100, 1'b1, 32'h80, 32'h100);
    checkOutput("wnt_taken_mispredict", {31'b0, ex_mispredict}, 32'h1);
    checkOutput("wnt_taken_pred_taken", {31'b0, pred_taken}, 32'h1);
    train(32'h100, 1'b1, 32'h80, 32'h100);
    checkOutput("wt_taken_mispredict", {31'b0, ex_mispredict}, 32'h0);

    // Target change on a strongly-taken hit.
    train(32'h100, 1'b1, 32'h90, 32'h100);
    checkOutput("tgt_change_mispredict", {31'b0, ex_mispredict}, 32'h1);
    checkOutput("tgt_change_pred_target", pred_target, 32'h90);

    // Aliasing: 0x140 shares index 0 with a different tag.
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 32'h140);
    checkOutput("alias_miss_pred_taken", {31'b0, pred_taken}, 32'h0);
    checkOutput("alias_miss_pred_target", pred_target, 32'h0);
    train(32'h140, 1'b1, 32'h200, 32'h140);
    checkOutput("alias_alloc_mispredict", {31'b0, ex_mispredict}, 32'h1);
    checkOutput("alias_pred_taken", {31'b0, pred_taken}, 32'h1);
    checkOutput("alias_pred_target", pred_target, 32'h200);
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 32'h100);
    checkOutput("evicted_pred_taken", {31'b0, pred_taken}, 32'h0);

    // Not-taken miss leaves the table alone and is not a mispredict.
    train(32'h100, 1'b0, 32'h0, 32'h140);
    checkOutput("nt_miss_mispredict", {31'b0, ex_mispredict}, 32'h0);
    checkOutput("nt_miss_keeps_alias", pred_target, 32'h200);

    // Separate index 1 (0x104) does not disturb index 0; low PC bits ignored.
    train(32'h104, 1'b1, 32'h300, 32'h107);
    checkOutput("idx1_pred_target", pred_target, 32'h300);
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 32'h142);
    checkOutput("idx0_still_target", pred_target, 32'h200);

    // Asynchronous reset mid-cycle with an update pending.
    applyStimulus(1'b1, 32'h180, 1'b1, 32'h400, 32'h140);
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst_pred_taken", {31'b0, pred_taken}, 32'h0);
    checkOutput("async_rst_pred_target", pred_target, 32'h0);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 32'h180);
    rst_n = 1'b1;
    tick();
    checkOutput("discarded_upd_pred_taken", {31'b0, pred_taken}, 32'h0);
    checkOutput("post_rst2_mispredict", {31'b0, ex_mispredict}, 32'h0);
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 32'h104);
    checkOutput("post_rst2_idx1_pred_taken", {31'b0, pred_taken}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_predictor_btb.md
Name: branch_predictor_btb

Overview:
- Bimodal branch predictor with a direct-mapped branch target buffer (BTB) for the pipelined RV32 core.
- Sits in IF, directly upstream of the PC-select 2:1 mux.
- Drives that mux's select (pred_taken) and its taken-path input (pred_target) from the current fetch PC.
- Trained from resolved branch/jump outcomes returned by EX.

Parameters:
- XLEN, 32, datapath/PC width.
- IDX_W, 4, index bits; ENTRIES = 2**IDX_W; index = pc[IDX_W+1:2].
- TAG_W, XLEN-IDX_W-2 (derived, localparam), tag = pc[XLEN-1:IDX_W+2].

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- if_pc  in  XLEN  current fetch PC.
- pred_taken  out  1  select for PC mux; 1 = fetch pred_target next.
- pred_target  out  XLEN  predicted target when pred_taken, else 0.
- ex_upd  in  1  EX has a resolved control-transfer instruction this cycle.
- ex_pc  in  XLEN  PC of the resolved instruction.
- ex_taken  in  1  actual outcome.
- ex_target  in  XLEN  actual target (valid when ex_taken).
- ex_mispredict  out  1  registered; high one cycle after an ex_upd whose outcome differs from the table's prediction for ex_pc at update time.

Behaviour:
- Clock and reset: one clock (clk). Reset rst_n is asynchronous, active-low.
- State per entry: valid (1), tag (TAG_W), target (XLEN), ctr (2-bit saturating: 00 SNT, 01 WNT, 10 WT, 11 ST).
- Reset: all valid=0, ctr=00, tags/targets=0, ex_mispredict=0.
  - pred_taken=0 and pred_target=0 for any if_pc while in reset and immediately after.
- Lookup: combinational, same cycle as if_pc.
  - hit = valid[idx] && tag[idx]==if_pc tag.
  - pred_taken = hit && ctr[idx][1].
  - pred_target = pred_taken ? target[idx] : 0.
  - if_pc[1:0] ignored.
- Update: on rising clk when ex_upd=1, at ex_pc's index. Let hit_u = tag/valid match for ex_pc.
  - hit_u and ex_taken: ctr = min(ctr+1, 11); target <= ex_target.
  - hit_u and !ex_taken: ctr = max(ctr-1, 00); target unchanged.
  - !hit_u and ex_taken: allocate/replace: valid=1, tag=ex_pc tag, target=ex_target, ctr=10.
  - !hit_u and !ex_taken: no change.
- ex_mispredict: registered, next edge after ex_upd.
  - Set when (hit_u && ctr[1]) != ex_taken, or when hit_u && ctr[1] && ex_taken && target != ex_target.
  - 0 in any cycle following ex_upd=0.
- Simultaneous lookup and update to the same index: lookup returns pre-update contents (no bypass). Update visible from the next cycle.
- Reset asserted mid-operation: table invalidated immediately (async). Pending update discarded.
- Latency: prediction 0 cycles; training 1 cycle; ex_mispredict 1 cycle after ex_upd.

Decomposition:
- Shared package bp_pkg holds:
  - counter encodings CTR_SNT/WNT/WT/ST;
  - CTR_INIT_TAKEN = CTR_WT;
  - index/tag slice helper constants.
- One natural sub-module: bp_sat_ctr2, a pure 2-bit saturating next-state function (inputs ctr, taken; output next ctr), instantiated once on the update path.
- Table storage stays inline as register arrays; no SRAM macro.

Test Plan:
- Reset, then if_pc=0x0000_0100 -> pred_taken=0, pred_target=0. ex_upd=0 keeps ex_mispredict=0.
- ex_upd, ex_pc=0x100, ex_taken=1, ex_target=0x80 -> ex_mispredict=1 next cycle; lookup 0x100 gives pred_taken=1, pred_target=0x80 (ctr=10).
- Continue from 10: two taken updates at 0x100 -> ctr=11 (saturates). One not-taken -> ctr=10, pred_taken still 1. Second not-taken -> ctr=01, pred_taken=0, pred_target=0, ex_mispredict=1.
- Alias, IDX_W=4: train 0x100 taken -> 0x80. Lookup 0x140 (same index 0, different tag) -> miss. Update 0x140 taken -> 0x200 -> 0x140 predicts 0x200; 0x100 now misses.
- Same cycle: ex_upd for 0x100 (first allocate) while if_pc=0x100 -> pred_taken=0 that cycle, 1 the next.
- Target change on hit: entry 0x100->0x80 with ctr=11; update taken with ex_target=0x90 -> ex_mispredict=1, next lookup pred_target=0x90. Assert rst_n low mid-sequence -> pred_taken drops to 0 immediately, asynchronously.
